baud_rate_gen: RTL and testbench

Free-running modulo-M counter that emits a one-clock-wide sampling tick (`s_tick`) every M system clocks. It sits at the front of the UART: the receiver and transmitter use `s_tick` as their oversampling enable (typically 16× the baud rate). With defaults M=163 and a 50 MHz clock it yields ≈19200 baud × 16. RTL module name is `baud_rate_gen`. The DUT instance name `baud_rate_generator` is a wrapper or alias of this block with an identical interface.

---
 rtl/baud_rate_gen.sv | 74 +++++++
 tb/tb_baud_rate_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/baud_rate_gen.sv
// Modulo-D sampling tick generator for the UART front end; s_tick pulses once every D clocks.
// Optional BAUD_RATE_DYN_DIV_EN adds a runtime-loadable divisor (div_load/div_val).
module baud_rate_gen #(
  parameter int M = 163,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
`ifdef BAUD_RATE_DYN_DIV_EN
  input  logic         div_load,
  input  logic [N-1:0] div_val,
`endif
  output logic         s_tick,
  output logic [N-1:0] q
);

  // M = 2^N truncates to 0 here; 0 - 1 in N bits is all-ones, so the wrap matches overflow.
  localparam logic [N-1:0] M_N = N'(M);

  generate
    if (M < 2 || M > (1 << N)) begin : g_bad_m
      $fatal(1, "baud_rate_gen: M must satisfy 2 <= M <= 2^N");
    end
  endgenerate

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] div_cur;
  logic [N-1:0] dm1;

`ifdef BAUD_RATE_DYN_DIV_EN
  logic [N-1:0] div_q, div_d;
  logic         load_ok;

  // Extra bit keeps the ">= 2" test meaningful even for very narrow counters.
  assign load_ok = div_load && ({1'b0, div_val} >= (N+1)'(2));

  always_comb begin
    div_d = div_q;
    if (load_ok) div_d = div_val;
  end

  assign div_cur = div_q;
`else
  assign div_cur = M_N;
`endif

  assign dm1 = div_cur - N'(1);

  // ">=" also recovers a count stranded above a freshly shortened divisor.
  always_comb begin
    cnt_d = (cnt_q >= dm1) ? '0 : cnt_q + N'(1);
`ifdef BAUD_RATE_DYN_DIV_EN
    if (load_ok) cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
`ifdef BAUD_RATE_DYN_DIV_EN
      div_q <= M_N;
`endif
    end else begin
      cnt_q <= cnt_d;
`ifdef BAUD_RATE_DYN_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign s_tick = (cnt_q == dm1);
  assign q      = cnt_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Scoreboard bench for baud_rate_gen: default M=163/N=8 instance plus a full-width M=4/N=2 instance.
// Runtime divisor load is exercised when BAUD_RATE_DYN_DIV_EN is defined.
module tb_baud_rate_gen;

`ifdef BAUD_RATE_DYN_DIV_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick0, s_tick1;
  logic [7:0] q0;
  logic [1:0] q1;
`ifdef BAUD_RATE_DYN_DIV_EN
  logic       div_load;
  logic [7:0] div_val;
  logic       div_load1;
  logic [1:0] div_val1;
`endif

  always #5 clk = ~clk;

  baud_rate_gen u_dut0 (
    .clk     (clk),
    .reset   (reset),
`ifdef BAUD_RATE_DYN_DIV_EN
    .div_load(div_load),
    .div_val (div_val),
`endif
    .s_tick  (s_tick0),
    .q       (q0)
  );

  baud_rate_gen #(.M(4), .N(2)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
`ifdef BAUD_RATE_DYN_DIV_EN
    .div_load(div_load1),
    .div_val (div_val1),
`endif
    .s_tick  (s_tick1),
    .q       (q1)
  );

  typedef struct {
    int q0;
    bit t0;
    int q1;
    bit t1;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mq0, md0, mq1;
  int   since0, gap0, since1, gap1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state, then pop and compare.
  task automatic step(input bit rst, input bit ld, input int val);
    exp_t e;
    bit   ev0;
    @(negedge clk);
    reset = rst;
`ifdef BAUD_RATE_DYN_DIV_EN
    div_load = ld;
    div_val  = val[7:0];
`endif
    ev0 = 1'b0;
    if (rst) begin
      mq0 = 0;
      md0 = 163;
      mq1 = 0;
    end else begin
      if (DYN && ld && val >= 2) begin
        md0 = val;
        mq0 = 0;
        ev0 = 1'b1;
      end else begin
        mq0 = (mq0 >= md0 - 1) ? 0 : mq0 + 1;
      end
      mq1 = (mq1 == 3) ? 0 : mq1 + 1;
    end
    e.q0 = mq0;
    e.t0 = (mq0 == md0 - 1);
    e.q1 = mq1;
    e.t1 = (mq1 == 3);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("q0",    {24'd0, q0},      e.q0);
    check_val("tick0", {31'd0, s_tick0}, {31'd0, e.t0});
    check_val("q1",    {30'd0, q1},      e.q1);
    check_val("tick1", {31'd0, s_tick1}, {31'd0, e.t1});

    if (rst) begin
      since0 = 0; gap0 = 162;
      since1 = 0; gap1 = 3;
    end else begin
      if (ev0) begin
        since0 = 0;
        gap0   = md0 - 1;
      end else begin
        since0++;
      end
      since1++;
      if (s_tick0) begin
        check_val("gap0", since0, gap0);
        since0 = 0;
        gap0   = md0;
      end
      if (s_tick1) begin
        check_val("gap1", since1, gap1);
        since1 = 0;
        gap1   = 4;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
`ifdef BAUD_RATE_DYN_DIV_EN
    div_load  = 1'b0;
    div_val   = 8'd0;
    div_load1 = 1'b0;
    div_val1  = 2'd0;
`endif
    mq0 = 0; md0 = 163; mq1 = 0;
    since0 = 0; gap0 = 162; since1 = 0; gap1 = 3;

    repeat (3) step(1'b1, 1'b0, 0);

    // Ten full periods of the default divisor after release.
    repeat (163 * 10 + 2) step(1'b0, 1'b0, 0);

    // Mid-count reset at q=100.
    for (int i = 0; i < 400 && mq0 != 100; i++) step(1'b0, 1'b0, 0);
    check_val("pre_rst_q", {24'd0, q0}, 100);
    step(1'b1, 1'b0, 0);
    repeat (170) step(1'b0, 1'b0, 0);

`ifdef BAUD_RATE_DYN_DIV_EN
    for (int i = 0; i < 400 && mq0 != 50; i++) step(1'b0, 1'b0, 0);
    check_val("pre_load_q", {24'd0, q0}, 50);
    step(1'b0, 1'b1, 10);
    check_val("load_q", {24'd0, q0}, 0);
    repeat (45) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1);
    repeat (40) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    repeat (340) step(1'b0, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
